fpu_normalizer_32: RTL and testbench
====================================

Name: fpu_normalizer_32

Overview:
- Pipelined post-arithmetic normalization stage of the FPU.
- Accepts an unnormalized 32-bit mantissa (hidden bit plus guard/round/sticky positions) with a signed biased exponent and sign.
- Counts leading zeros with an internal leading_zero_counter_32 instance, left-shifts the mantissa so the MSB lands at bit 31, and adjusts the exponent.
- Output feeds the rounding stage through a valid/ready handshake; the shift is clamped so the exponent never drops below 1 (subnormal result).

Parameters:
- EXP_WIDTH, 10: width of the signed two's-complement biased exponent on input and output (bias 127 applied upstream).

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- valid_in  input  1  upstream data valid
- ready_in  output  1  this block can accept data this cycle
- sign_in  input  1  operand sign
- exp_in  input  EXP_WIDTH  signed biased exponent
- man_in  input  32  unnormalized mantissa
- valid_out  output  1  result valid
- ready_out  input  1  downstream accepts result
- sign_out  output  1  sign, passed through
- exp_out  output  EXP_WIDTH  adjusted exponent
- man_out  output  32  normalized mantissa
- zero_out  output  1  man_in was all zeros
- subnormal_out  output  1  shift clamped; result not fully normalized

Behaviour:
- Reset (async assert, sync release): every pipeline register and every output is 0. This includes valid_out, man_out, exp_out, sign_out, zero_out and subnormal_out.
- ready_in is combinational: 1 whenever stage-1 is empty or stage-1 advances this cycle. It is therefore 1 out of reset.
- Two register stages:
  - S1 captures the inputs plus the LZC result (lz, 5 bits, and the all-zero flag a).
  - S2 holds the shifted result.
- Latency is 2 cycles from an input handshake (valid_in && ready_in) to valid_out, with no stalls. Throughput is one item per cycle.
- Handshakes:
  - An input transfer occurs on valid_in && ready_in. An output transfer occurs on valid_out && ready_out.
  - S2 loads when it is empty or its output transfers. S1 advances when S2 loads.
- Stall: when valid_out && !ready_out, all S2 outputs hold stable, and S1 holds if it is full. No data is lost or duplicated, and there are no bubbles when ready_out is held at 1.
- Once valid_out rises, it must not fall until the transfer completes.
- S2 computation, with e = exp_in from S1 treated as signed:
  - Zero case: a=1 (man=0) gives zero_out=1, man_out=0, exp_out=0, subnormal_out=0. sign passes through.
  - Clamp: if e > 1, then maxsh = e-1, else maxsh = 0.
  - Shift: sh = min(lz, maxsh). man_out = man << sh, with zeros shifted in. exp_out = e - sh.
  - subnormal_out = (sh < lz).
  - No shift when e ≤ 1; negative exponents pass through unchanged for the rounder to right-shift.
- Arithmetic: the comparison and subtraction are done in EXP_WIDTH+1 bits and cannot overflow, because lz ≤ 31 and sh ≤ e-1.
- Reset mid-operation: in-flight items are discarded, and valid_out drops asynchronously.
- Simultaneous input and output transfer while both stages are full: S2 takes S1, and S1 takes the new input in the same cycle.

Test Plan:
- Simple normalize: man_in=0x0000_8000, exp_in=150, sign=1 → 2 cycles later man_out=0x8000_0000, exp_out=134, sign_out=1, zero_out=0, subnormal_out=0.
- Already normalized: man_in=0x8000_0001, exp_in=127 → man_out=0x8000_0001, exp_out=127, subnormal_out=0.
- Zero input: man_in=0, exp_in=100 → zero_out=1, man_out=0, exp_out=0.
- Subnormal clamp: man_in=0x0000_0100 (lz=23), exp_in=5 → sh=4, man_out=0x0000_1000, exp_out=1, subnormal_out=1.
- Negative exponent: man_in=0x0000_0001, exp_in=-3 → sh=0, man_out unchanged, exp_out=-3, subnormal_out=1.
- Backpressure: stream 5 back-to-back items with ready_out low for cycles 3–6.
  - Required: ready_in drops once both stages are full, outputs stay stable while stalled, and all 5 results emerge in order with no loss or duplication.
  - Then assert reset_n=0 mid-stream: valid_out=0 immediately, and all outputs are 0.

Source files
------------

// File: rtl/fpu_normalizer_32.sv
// fpu_normalizer_32: two-stage post-arithmetic normalizer with valid/ready flow control.
//   clk, reset_n             : clock (rising edge), async active-low reset
//   valid_in / ready_in      : upstream handshake (ready_in is combinational)
//   sign_in, exp_in, man_in  : operand sign, signed biased exponent, raw 32-bit mantissa
//   valid_out / ready_out    : downstream handshake towards the rounder
//   sign_out, exp_out, man_out, zero_out, subnormal_out : normalized result and flags
// leading_zero_counter_32: combinational count of leading zeros plus all-zero flag.
//   value : input word, count : leading zeros (0 when value is 0), all_zero : value == 0

module leading_zero_counter_32 (
  input  logic [31:0] value,
  output logic [4:0]  count,
  output logic        all_zero
);

  logic found;

  // Priority scan from the MSB; first set bit determines the count.
  always_comb begin
    count    = '0;
    found    = 1'b0;
    all_zero = (value == 32'h0);
    for (int i = 31; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 5'(31 - i);
        found = 1'b1;
      end
    end
  end

endmodule

module fpu_normalizer_32 #(
  parameter int unsigned EXP_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic                 sign_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [31:0]          man_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 sign_out,
  output logic [EXP_WIDTH-1:0] exp_out,
  output logic [31:0]          man_out,
  output logic                 zero_out,
  output logic                 subnormal_out
);

  // One extra bit so the signed clamp compare cannot overflow.
  localparam int unsigned XW = EXP_WIDTH + 1;

  logic [4:0]           lz_c;
  logic                 zero_c;

  logic                 s1_valid;
  logic                 s1_sign;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [31:0]          s1_man;
  logic [4:0]           s1_lz;
  logic                 s1_zero;

  logic                 s2_load;
  logic                 in_xfer;

  logic signed [XW-1:0] e_x;
  logic signed [XW-1:0] lz_x;
  logic signed [XW-1:0] maxsh;
  logic [4:0]           sh;
  logic                 sub_c;
  logic [31:0]          man_sh;
  logic [EXP_WIDTH-1:0] exp_sh;

  leading_zero_counter_32 u_lzc (
    .value    (man_in),
    .count    (lz_c),
    .all_zero (zero_c)
  );

  // S2 refills when empty or draining; S1 moves whenever S2 refills.
  assign s2_load  = !valid_out || ready_out;
  assign ready_in = !s1_valid || s2_load;
  assign in_xfer  = valid_in && ready_in;

  // Stage 1: capture operands plus LZC result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_lz    <= '0;
      s1_zero  <= 1'b0;
    end else begin
      if (ready_in) begin
        s1_valid <= valid_in;
      end
      if (in_xfer) begin
        s1_sign <= sign_in;
        s1_exp  <= exp_in;
        s1_man  <= man_in;
        s1_lz   <= lz_c;
        s1_zero <= zero_c;
      end
    end
  end

  // Clamped shift amount: never drive the exponent below 1.
  always_comb begin
    e_x    = {s1_exp[EXP_WIDTH-1], s1_exp};
    lz_x   = XW'(s1_lz);
    maxsh  = (e_x > XW'(1)) ? (e_x - XW'(1)) : '0;
    sh     = (lz_x <= maxsh) ? s1_lz : maxsh[4:0];
    sub_c  = (sh < s1_lz);
    man_sh = s1_man << sh;
    exp_sh = s1_exp - EXP_WIDTH'(sh);
  end

  // Stage 2: registered normalized result; holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out     <= 1'b0;
      sign_out      <= 1'b0;
      exp_out       <= '0;
      man_out       <= '0;
      zero_out      <= 1'b0;
      subnormal_out <= 1'b0;
    end else if (s2_load) begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        sign_out <= s1_sign;
        zero_out <= s1_zero;
        if (s1_zero) begin
          man_out       <= '0;
          exp_out       <= '0;
          subnormal_out <= 1'b0;
        end else begin
          man_out       <= man_sh;
          exp_out       <= exp_sh;
          subnormal_out <= sub_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_normalizer_32.sv
// tb_fpu_normalizer_32: directed self-checking bench for fpu_normalizer_32.
module tb_fpu_normalizer_32;

  localparam int unsigned EW = 10;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_in;
  logic          ready_in;
  logic          sign_in;
  logic [EW-1:0] exp_in;
  logic [31:0]   man_in;
  logic          valid_out;
  logic          ready_out;
  logic          sign_out;
  logic [EW-1:0] exp_out;
  logic [31:0]   man_out;
  logic          zero_out;
  logic          subnormal_out;

  int tests = 0;
  int fails = 0;

  // Stimulus and hand-computed results.
  logic          t_sign [NV];
  logic [EW-1:0] t_exp  [NV];
  logic [31:0]   t_man  [NV];
  logic [31:0]   r_man  [NV];
  logic [EW-1:0] r_exp  [NV];
  logic          r_zero [NV];
  logic          r_sub  [NV];

  always #5 clk = ~clk;

  fpu_normalizer_32 #(.EXP_WIDTH(EW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .sign_in       (sign_in),
    .exp_in        (exp_in),
    .man_in        (man_in),
    .valid_out     (valid_out),
    .ready_out     (ready_out),
    .sign_out      (sign_out),
    .exp_out       (exp_out),
    .man_out       (man_out),
    .zero_out      (zero_out),
    .subnormal_out (subnormal_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, req);
    end
  endtask

  task automatic check_out(input int i, input string pre);
    check($sformatf("%s%0d.man", pre, i),  man_out,              r_man[i]);
    check($sformatf("%s%0d.exp", pre, i),  32'(exp_out),         32'(r_exp[i]));
    check($sformatf("%s%0d.sign", pre, i), 32'(sign_out),        32'(t_sign[i]));
    check($sformatf("%s%0d.zero", pre, i), 32'(zero_out),        32'(r_zero[i]));
    check($sformatf("%s%0d.sub", pre, i),  32'(subnormal_out),   32'(r_sub[i]));
  endtask

  task automatic drive(input int i);
    valid_in = 1'b1;
    sign_in  = t_sign[i];
    exp_in   = t_exp[i];
    man_in   = t_man[i];
  endtask

  initial begin
    int            nxt;
    int            got;
    int            idx;
    int            q[$];
    logic          stalled;
    logic [31:0]   p_man;
    logic [EW-1:0] p_exp;
    logic          p_sign;

    // idx: sign, exp, man -> man_out, exp_out, zero, subnormal
    t_sign[0] = 1'b1; t_exp[0] = 10'd150;  t_man[0] = 32'h0000_8000; r_man[0] = 32'h8000_0000; r_exp[0] = 10'd134;  r_zero[0] = 1'b0; r_sub[0] = 1'b0;
    t_sign[1] = 1'b0; t_exp[1] = 10'd127;  t_man[1] = 32'h8000_0001; r_man[1] = 32'h8000_0001; r_exp[1] = 10'd127;  r_zero[1] = 1'b0; r_sub[1] = 1'b0;
    t_sign[2] = 1'b1; t_exp[2] = 10'd100;  t_man[2] = 32'h0000_0000; r_man[2] = 32'h0000_0000; r_exp[2] = 10'd0;    r_zero[2] = 1'b1; r_sub[2] = 1'b0;
    t_sign[3] = 1'b0; t_exp[3] = 10'd5;    t_man[3] = 32'h0000_0100; r_man[3] = 32'h0000_1000; r_exp[3] = 10'd1;    r_zero[3] = 1'b0; r_sub[3] = 1'b1;
    t_sign[4] = 1'b1; t_exp[4] = 10'h3FD;  t_man[4] = 32'h0000_0001; r_man[4] = 32'h0000_0001; r_exp[4] = 10'h3FD;  r_zero[4] = 1'b0; r_sub[4] = 1'b1;
    t_sign[5] = 1'b0; t_exp[5] = 10'd1;    t_man[5] = 32'h4000_0000; r_man[5] = 32'h4000_0000; r_exp[5] = 10'd1;    r_zero[5] = 1'b0; r_sub[5] = 1'b1;
    t_sign[6] = 1'b0; t_exp[6] = 10'd2;    t_man[6] = 32'h4000_0000; r_man[6] = 32'h8000_0000; r_exp[6] = 10'd1;    r_zero[6] = 1'b0; r_sub[6] = 1'b0;
    t_sign[7] = 1'b0; t_exp[7] = 10'd200;  t_man[7] = 32'h0000_0001; r_man[7] = 32'h8000_0000; r_exp[7] = 10'd169;  r_zero[7] = 1'b0; r_sub[7] = 1'b0;

    reset_n   = 1'b0;
    valid_in  = 1'b0;
    sign_in   = 1'b0;
    exp_in    = '0;
    man_in    = '0;
    ready_out = 1'b0;

    // Reset state
    #12;
    check("rst.valid_out", 32'(valid_out), 32'd0);
    check("rst.man_out",   man_out, 32'd0);
    check("rst.exp_out",   32'(exp_out), 32'd0);
    check("rst.sign_out",  32'(sign_out), 32'd0);
    check("rst.zero_out",  32'(zero_out), 32'd0);
    check("rst.sub_out",   32'(subnormal_out), 32'd0);
    check("rst.ready_in",  32'(ready_in), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single transactions: two-cycle latency and result fields
    ready_out = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(i);
      #1 check($sformatf("one%0d.ready_in", i), 32'(ready_in), 32'd1);
      @(negedge clk);
      valid_in = 1'b0;
      #1 check($sformatf("one%0d.lat1", i), 32'(valid_out), 32'd0);
      @(negedge clk);
      #1 check($sformatf("one%0d.valid", i), 32'(valid_out), 32'd1);
      check_out(i, "one");
    end
    @(negedge clk);
    #1 check("drain.valid", 32'(valid_out), 32'd0);

    // Back-to-back stream with ready_out low for cycles 3..6
    nxt     = 0;
    got     = 0;
    stalled = 1'b0;
    p_man   = '0;
    p_exp   = '0;
    p_sign  = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      ready_out = !(c >= 3 && c <= 6);
      if (nxt < 5) drive(nxt);
      else valid_in = 1'b0;
      #1;
      if (c == 3) check("bp.ready_in_low", 32'(ready_in), 32'd0);
      if (stalled) begin
        check("bp.hold_valid", 32'(valid_out), 32'd1);
        check("bp.hold_man",   man_out, p_man);
        check("bp.hold_exp",   32'(exp_out), 32'(p_exp));
        check("bp.hold_sign",  32'(sign_out), 32'(p_sign));
      end
      if (valid_out && ready_out) begin
        if (q.size() == 0) begin
          check("bp.unexpected", 32'(valid_out), 32'd0);
        end else begin
          idx = q.pop_front();
          check_out(idx, "bp");
          got++;
        end
      end
      stalled = valid_out && !ready_out;
      p_man   = man_out;
      p_exp   = exp_out;
      p_sign  = sign_out;
      if (valid_in && ready_in) begin
        q.push_back(nxt);
        nxt++;
      end
    end
    valid_in = 1'b0;
    check("bp.count", 32'(got), 32'd5);
    check("bp.leftover", 32'(q.size()), 32'd0);

    // Reset mid-stream with both stages full
    ready_out = 1'b0;
    @(negedge clk);
    drive(0);
    @(negedge clk);
    drive(3);
    @(negedge clk);
    valid_in = 1'b0;
    #1 check("mid.valid_before", 32'(valid_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid.valid_out", 32'(valid_out), 32'd0);
    check("mid.man_out",   man_out, 32'd0);
    check("mid.exp_out",   32'(exp_out), 32'd0);
    check("mid.sign_out",  32'(sign_out), 32'd0);
    check("mid.zero_out",  32'(zero_out), 32'd0);
    check("mid.sub_out",   32'(subnormal_out), 32'd0);
    check("mid.ready_in",  32'(ready_in), 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    ready_out = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("post.no_stale", 32'(valid_out), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
